// File: rtl/lsu_riscv.sv
// Load/store unit: req/gnt/rvalid data-memory handshake, core stall, load extension.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of issuing them.
module lsu_riscv #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_data_i,
  output logic              lsu_stall_req_o,
  output logic [31:0]       lsu_data_o,
  output logic              lsu_misalign_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t      state;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [31:0] ldata_q;

  logic [1:0]  off;
  logic        legal_size;
  logic        misalign_cond;
  logic        valid;
  logic        issue;
  logic        granted;
  logic        done;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  assign off = lsu_addr_i[1:0];

  always_comb begin
    legal_size = 1'b0;
    case (lsu_size_i)
      LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: legal_size = 1'b1;
      default: legal_size = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign_cond = 1'b0;
    case (lsu_size_i)
      LDST_H, LDST_HU: misalign_cond = off[0];
      LDST_W:          misalign_cond = (off != 2'b00);
      default:         misalign_cond = 1'b0;
    endcase
  end
  assign lsu_misalign_o = lsu_req_i & legal_size & misalign_cond & ~rst_i;
`else
  assign misalign_cond  = 1'b0;
  assign lsu_misalign_o = 1'b0;
`endif

  // Request/stall are combinational so an IDLE request reaches memory in the same cycle.
  assign valid   = lsu_req_i & legal_size & ~misalign_cond & ~rst_i;
  assign issue   = ((state == IDLE) & valid) | (state == WAIT_GNT);
  assign granted = issue & data_gnt_i;
  assign done    = (state == WAIT_RVALID) & data_rvalid_i;

  assign lsu_stall_req_o = ((state == IDLE) & valid) | (state == WAIT_GNT) |
                           ((state == WAIT_RVALID) & ~data_rvalid_i);

  always_comb begin
    be    = 4'b1111;
    wdata = lsu_data_i;
    case (lsu_size_i[1:0])
      2'd0: begin
        be    = 4'b0001 << off;
        wdata = {4{lsu_data_i[7:0]}};
      end
      2'd1: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{lsu_data_i[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = lsu_data_i;
      end
    endcase
  end

  assign data_req_o   = issue;
  assign data_we_o    = issue & lsu_we_i;
  assign data_be_o    = issue ? be : 4'b0000;
  assign data_addr_o  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
  assign data_wdata_o = wdata;

  always_comb begin
    rbyte = data_rdata_i[7:0];
    case (off_q)
      2'd0: rbyte = data_rdata_i[7:0];
      2'd1: rbyte = data_rdata_i[15:8];
      2'd2: rbyte = data_rdata_i[23:16];
      default: rbyte = data_rdata_i[31:24];
    endcase
    rhalf = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    ext   = data_rdata_i;
    case (size_q)
      LDST_B:  ext = {{24{rbyte[7]}}, rbyte};
      LDST_BU: ext = {24'h0, rbyte};
      LDST_H:  ext = {{16{rhalf[15]}}, rhalf};
      LDST_HU: ext = {16'h0, rhalf};
      default: ext = data_rdata_i;
    endcase
  end

  assign lsu_data_o = (done & ~we_q) ? ext : ldata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      ldata_q <= 32'h0;
    end else begin
      if (granted) begin
        size_q <= lsu_size_i;
        off_q  <= off;
        we_q   <= lsu_we_i;
      end
      case (state)
        IDLE: begin
          if (valid) state <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
        WAIT_GNT: begin
          if (data_gnt_i) state <= WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state <= IDLE;
            if (!we_q) ldata_q <= ext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_riscv.sv
// Randomized self-checking bench for lsu_riscv against a behavioural access model.
module tb_lsu_riscv;
  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_data;
  logic        lsu_stall, lsu_misalign;
  logic [31:0] lsu_rdata_out;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;

  int total = 0;
  int bad = 0;
  logic [31:0] model_ldata;

  always #5 clk = ~clk;

  lsu_riscv #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
    .lsu_stall_req_o(lsu_stall), .lsu_data_o(lsu_rdata_out), .lsu_misalign_o(lsu_misalign),
    .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
    .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] sz);
    return (sz == 3'd0) || (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4) || (sz == 3'd5);
  endfunction

  function automatic bit is_mis(input logic [2:0] sz, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 3'd1 || sz == 3'd5) return off[0];
    if (sz == 3'd2) return off != 2'd0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] e_be(input logic [2:0] sz, input logic [1:0] off);
    if (sz == 3'd0 || sz == 3'd4) return 32'd1 << off;
    if (sz == 3'd1 || sz == 3'd5) return 32'd3 << (2 * int'(off[1]));
    return 32'd15;
  endfunction

  function automatic logic [31:0] e_wdata(input logic [2:0] sz, input logic [31:0] d);
    if (sz == 3'd0 || sz == 3'd4) return 32'(d[7:0]) * 32'h01010101;
    if (sz == 3'd1 || sz == 3'd5) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] e_ext(input logic [2:0] sz, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (sz)
      3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4: return b;
      3'd1: return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  // One complete access: gd cycles of grant delay, rd cycles of response delay.
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] d, input int gd, input int rd,
                        input logic [31:0] rdata, input bit hold);
    bit issued;
    logic [31:0] seen_be;
    issued  = is_legal(sz) && !is_mis(sz, addr[1:0]);
    seen_be = 32'd0;
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = we; lsu_size = sz; lsu_addr = addr; lsu_data = d;
    data_gnt = 1'b0; data_rvalid = 1'b0;
    if (!issued) begin
      #1;
      chk("noop_req", 32'(data_req), 32'd0);
      chk("noop_stall", 32'(lsu_stall), 32'd0);
      chk("noop_misalign", 32'(lsu_misalign), 32'(is_legal(sz) && is_mis(sz, addr[1:0])));
      chk("noop_ldata", lsu_rdata_out, model_ldata);
      @(posedge clk);
    end else begin
      for (int k = 0; k <= gd; k++) begin
        if (k > 0) @(negedge clk);
        data_gnt    = (k == gd);
        data_rvalid = 1'($urandom_range(0, 1));
        data_rdata  = $urandom;
        #1;
        chk("req", 32'(data_req), 32'd1);
        chk("we", 32'(data_we), 32'(we));
        chk("be", 32'(data_be), e_be(sz, addr[1:0]));
        chk("addr", data_addr, addr & 32'hFFFF_FFFC);
        if (we) chk("wdata", data_wdata, e_wdata(sz, d));
        chk("stall_gnt", 32'(lsu_stall), 32'd1);
        chk("misalign", 32'(lsu_misalign), 32'd0);
        seen_be = 32'(data_be);
        @(posedge clk);
      end
      for (int k = 0; k <= rd; k++) begin
        @(negedge clk);
        data_gnt    = 1'($urandom_range(0, 1));
        data_rvalid = (k == rd);
        data_rdata  = (k == rd) ? rdata : $urandom;
        #1;
        chk("req_wait", 32'(data_req), 32'd0);
        chk("stall_wait", 32'(lsu_stall), 32'(k != rd));
        if (k == rd && !we) model_ldata = e_ext(sz, addr[1:0], rdata);
        chk("ldata", lsu_rdata_out, model_ldata);
        @(posedge clk);
      end
    end
    $display("txn we=%0d size=%0d addr=%h gd=%0d rd=%0d issued=%0d be=%h ldata=%h",
             we, sz, addr, gd, rd, issued, seen_be, lsu_rdata_out);
    if (!hold) begin
      @(negedge clk);
      lsu_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0;
      #1;
      chk("idle_req", 32'(data_req), 32'd0);
      chk("idle_stall", 32'(lsu_stall), 32'd0);
      chk("idle_ldata", lsu_rdata_out, model_ldata);
      @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'd0; lsu_addr = 32'h0;
    lsu_data = 32'h0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0;
    model_ldata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_we", 32'(data_we), 32'd0);
    chk("rst_be", 32'(data_be), 32'd0);
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    chk("rst_misalign", 32'(lsu_misalign), 32'd0);
    chk("rst_ldata", lsu_rdata_out, 32'd0);
    rst = 1'b0;
    @(posedge clk);

    // Directed scenarios
    access(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
    chk("lw_value", model_ldata, 32'hDEADBEEF);
    access(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, 1'b0);
    chk("lb_value", lsu_rdata_out, 32'hFFFFFF80);
    access(1'b0, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, 1'b0);
    chk("lbu_value", lsu_rdata_out, 32'h00000080);
    access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 3, 1, 32'h0, 1'b0);
    access(1'b0, 3'd1, 32'h101, 32'h0, 0, 0, 32'h0000_8001, 1'b0);
    access(1'b0, 3'd2, 32'h300, 32'h0, 0, 0, 32'hCAFEF00D, 1'b1);
    access(1'b1, 3'd2, 32'h304, 32'h55AA55AA, 0, 0, 32'h0, 1'b0);
    access(1'b0, 3'd3, 32'h308, 32'h0, 0, 0, 32'h0, 1'b0);

    // Reset while waiting for the response, then a stray rvalid
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h400; data_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; lsu_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0;
    #1;
    model_ldata = 32'h0;
    chk("mid_rst_req", 32'(data_req), 32'd0);
    chk("mid_rst_stall", 32'(lsu_stall), 32'd0);
    chk("mid_rst_be", 32'(data_be), 32'd0);
    chk("mid_rst_ldata", lsu_rdata_out, model_ldata);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h12345678;
    #1;
    chk("stray_req", 32'(data_req), 32'd0);
    chk("stray_stall", 32'(lsu_stall), 32'd0);
    chk("stray_ldata", lsu_rdata_out, model_ldata);
    @(posedge clk);
    @(negedge clk);
    data_rvalid = 1'b0;
    #1;
    chk("post_stray_ldata", lsu_rdata_out, model_ldata);
    @(posedge clk);

    // Randomized accesses
    for (int i = 0; i < 300; i++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
